// File: rtl/palette_lut_pipe.sv
// Runtime-writable multi-bank colour palette with a 2-cycle lookup pipeline,
// frame-synchronous bank switching and a frame-stepped brightness fade engine.
module palette_lut_pipe #(
  parameter int INDEX_W          = 4,
  parameter int CH_W             = 4,
  parameter int BANKS            = 2,
  parameter int TRANSP_INDEX     = 0,
  parameter int FADE_STEP_FRAMES = 4,
  localparam int BANK_W          = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid,
  input  logic [INDEX_W-1:0]  pix_index,
  input  logic                frame_start,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                bank_sel_wr,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic                fade_cmd_valid,
  input  logic                fade_cmd,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                out_valid,
  output logic                out_transparent,
  output logic [BANK_W-1:0]   active_bank,
  output logic [4:0]          brightness,
  output logic                fade_busy
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int CNT_W   = $clog2(FADE_STEP_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  logic [3*CH_W-1:0] mem_r [BANKS][ENTRIES];
  logic [3*CH_W-1:0] s1_data_r;
  logic              s1_valid_r;
  logic              s1_transp_r;
  logic [BANK_W-1:0] active_bank_r;
  logic [BANK_W-1:0] pend_bank_r;
  logic              pend_valid_r;
  fade_state_t       state_r, state_s;
  logic [4:0]        bright_r, bright_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              bank_sel_ok_s;

  // (c * level) >> 4 evaluated at CH_W+5 bits, keeping the low CH_W bits
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [4:0] lvl);
    logic [CH_W+4:0] prod;
    prod = {5'd0, c} * {{CH_W{1'b0}}, lvl};
    return prod[CH_W+3:4];
  endfunction

  assign bank_sel_ok_s = (int'(bank_sel) < BANKS);

  // Palette storage; the stage-1 read below sees the pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int e = 0; e < ENTRIES; e++)
          mem_r[b][e] <= '0;
    end else if (wr_en && (int'(wr_bank) < BANKS)) begin
      mem_r[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Lookup stage 1 and stage 2 (brightness scaling, colour held when idle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_r       <= '0;
      s1_valid_r      <= 1'b0;
      s1_transp_r     <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
      out_valid       <= 1'b0;
      out_transparent <= 1'b0;
    end else begin
      s1_data_r   <= mem_r[active_bank_r][pix_index];
      s1_valid_r  <= pix_valid;
      s1_transp_r <= pix_valid && (int'(pix_index) == TRANSP_INDEX);
      out_valid   <= s1_valid_r;
      out_transparent <= s1_transp_r;
      if (s1_valid_r) begin
        red   <= scale(s1_data_r[3*CH_W-1:2*CH_W], bright_r);
        green <= scale(s1_data_r[2*CH_W-1:CH_W], bright_r);
        blue  <= scale(s1_data_r[CH_W-1:0], bright_r);
      end
    end
  end

  // Bank requests stay pending until frame_start; a same-cycle request wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank_r <= '0;
      pend_bank_r   <= '0;
      pend_valid_r  <= 1'b0;
    end else if (frame_start) begin
      pend_valid_r <= 1'b0;
      if (bank_sel_wr && bank_sel_ok_s) begin
        active_bank_r <= bank_sel;
      end else if (pend_valid_r) begin
        active_bank_r <= pend_bank_r;
      end
    end else if (bank_sel_wr && bank_sel_ok_s) begin
      pend_bank_r  <= bank_sel;
      pend_valid_r <= 1'b1;
    end
  end

  // Fade engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      bright_r <= 5'd16;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_s;
      bright_r <= bright_s;
      cnt_r    <= cnt_s;
    end
  end

  // Fade engine next-state: one brightness step per FADE_STEP_FRAMES frames
  always_comb begin
    state_s  = state_r;
    bright_s = bright_r;
    cnt_s    = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (fade_cmd_valid && !fade_cmd && (bright_r != 5'd0)) begin
          state_s = FADE_OUT;
        end else if (fade_cmd_valid && fade_cmd && (bright_r != 5'd16)) begin
          state_s = FADE_IN;
        end else begin
          state_s = IDLE;
        end
      end
      FADE_OUT, FADE_IN: begin
        if (frame_start) begin
          if (cnt_r == CNT_W'(FADE_STEP_FRAMES - 1)) begin
            cnt_s = '0;
            if (state_r == FADE_OUT) begin
              bright_s = bright_r - 5'd1;
              state_s  = (bright_r == 5'd1) ? IDLE : FADE_OUT;
            end else begin
              bright_s = bright_r + 5'd1;
              state_s  = (bright_r == 5'd15) ? IDLE : FADE_IN;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  assign active_bank = active_bank_r;
  assign brightness  = bright_r;
  assign fade_busy   = (state_r != IDLE);

endmodule

// File: tb/tb_palette_lut_pipe.sv
// Directed self-checking bench for palette_lut_pipe with hand-computed expectations.
module tb_palette_lut_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        frame_start;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        bank_sel_wr;
  logic [0:0]  bank_sel;
  logic        fade_cmd_valid;
  logic        fade_cmd;
  logic [3:0]  red, green, blue;
  logic        out_valid, out_transparent;
  logic [0:0]  active_bank;
  logic [4:0]  brightness;
  logic        fade_busy;

  int checks = 0;
  int failures = 0;

  palette_lut_pipe dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_index(pix_index),
    .frame_start(frame_start), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .bank_sel_wr(bank_sel_wr), .bank_sel(bank_sel),
    .fade_cmd_valid(fade_cmd_valid), .fade_cmd(fade_cmd), .red(red), .green(green),
    .blue(blue), .out_valid(out_valid), .out_transparent(out_transparent),
    .active_bank(active_bank), .brightness(brightness), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:0] b, input logic [3:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fs(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic fade(input logic cmd);
    fade_cmd_valid = 1'b1; fade_cmd = cmd;
    tick();
    fade_cmd_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [3:0] idx, input logic [11:0] exp_rgb,
                        input logic exp_tr);
    pix_valid = 1'b1; pix_index = idx;
    tick();
    pix_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_rgb"}, {20'd0, red, green, blue}, {20'd0, exp_rgb});
    chk({tag, "_transp"}, {31'd0, out_transparent}, {31'd0, exp_tr});
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; pix_index = 4'd0; frame_start = 1'b0;
    wr_en = 1'b0; wr_bank = 1'b0; wr_addr = 4'd0; wr_data = 12'd0;
    bank_sel_wr = 1'b0; bank_sel = 1'b0; fade_cmd_valid = 1'b0; fade_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    chk("rst_bright", {27'd0, brightness}, 32'd16);
    chk("rst_bank", {31'd0, active_bank}, 32'd0);
    chk("rst_busy", {31'd0, fade_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic lookup, transparency, hold behaviour
    wr(1'b0, 4'd5, 12'hABC);
    lookup("lk5", 4'd5, 12'hABC, 1'b0);
    tick();
    chk("hold_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_rgb", {20'd0, red, green, blue}, 32'hABC);
    lookup("lk0", 4'd0, 12'h000, 1'b1);

    // back-to-back lookups with read-before-write on entry 2
    wr(1'b0, 4'd1, 12'h111);
    wr(1'b0, 4'd2, 12'h222);
    wr(1'b0, 4'd3, 12'h333);
    pix_valid = 1'b1; pix_index = 4'd1;
    tick();
    pix_index = 4'd2; wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd2; wr_data = 12'hFFF;
    tick();
    chk("b2b_v1", {31'd0, out_valid}, 32'd1);
    chk("b2b_1", {20'd0, red, green, blue}, 32'h111);
    wr_en = 1'b0; pix_index = 4'd3;
    tick();
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    chk("b2b_2_old", {20'd0, red, green, blue}, 32'h222);
    pix_valid = 1'b0;
    tick();
    chk("b2b_v3", {31'd0, out_valid}, 32'd1);
    chk("b2b_3", {20'd0, red, green, blue}, 32'h333);
    lookup("lk2_new", 4'd2, 12'hFFF, 1'b0);

    // bank switch deferred to frame_start
    wr(1'b1, 4'd5, 12'h123);
    bank_sel_wr = 1'b1; bank_sel = 1'b1;
    tick();
    bank_sel_wr = 1'b0;
    lookup("pend_lk", 4'd5, 12'hABC, 1'b0);
    chk("pend_bank", {31'd0, active_bank}, 32'd0);
    fs(1);
    chk("sw_bank", {31'd0, active_bank}, 32'd1);
    lookup("sw_lk", 4'd5, 12'h123, 1'b0);
    bank_sel_wr = 1'b1; bank_sel = 1'b0; frame_start = 1'b1;
    tick();
    bank_sel_wr = 1'b0; frame_start = 1'b0;
    chk("same_cyc_bank", {31'd0, active_bank}, 32'd0);
    bank_sel_wr = 1'b1; bank_sel = 1'b1;
    tick();
    bank_sel = 1'b0;
    tick();
    bank_sel_wr = 1'b0;
    chk("ovr_pend_bank", {31'd0, active_bank}, 32'd0);
    fs(1);
    chk("ovr_bank", {31'd0, active_bank}, 32'd0);

    // fade out 16 -> 0
    fade(1'b0);
    chk("fo_busy", {31'd0, fade_busy}, 32'd1);
    fs(3);
    chk("fo_b16", {27'd0, brightness}, 32'd16);
    fs(1);
    chk("fo_b15", {27'd0, brightness}, 32'd15);
    lookup("fo_fff", 4'd2, 12'hEEE, 1'b0);
    lookup("fo_abc", 4'd5, 12'h9AB, 1'b0);
    fs(59);
    chk("fo_b1", {27'd0, brightness}, 32'd1);
    chk("fo_b1_busy", {31'd0, fade_busy}, 32'd1);
    fs(1);
    chk("fo_b0", {27'd0, brightness}, 32'd0);
    chk("fo_done", {31'd0, fade_busy}, 32'd0);
    lookup("fo_black", 4'd2, 12'h000, 1'b0);
    fade(1'b0);
    chk("fo_noop", {31'd0, fade_busy}, 32'd0);

    // fade in with an ignored mid-fade command
    fade(1'b1);
    chk("fi_busy", {31'd0, fade_busy}, 32'd1);
    fs(4);
    chk("fi_b1", {27'd0, brightness}, 32'd1);
    lookup("fi_fff_b1", 4'd2, 12'h000, 1'b0);
    fade(1'b0);
    fs(4);
    chk("fi_b2", {27'd0, brightness}, 32'd2);
    chk("fi_busy2", {31'd0, fade_busy}, 32'd1);
    lookup("fi_abc_b2", 4'd5, 12'h111, 1'b0);

    // reset mid-fade and mid-pipeline
    pix_valid = 1'b1; pix_index = 4'd2;
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_bright", {27'd0, brightness}, 32'd16);
    chk("mid_rst_busy", {31'd0, fade_busy}, 32'd0);
    pix_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    lookup("post_rst_clr", 4'd5, 12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
